// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a two-entry
// prefetch FIFO, and a registered output stage feeding the IF/ID register.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] ibus,
  output logic [63:0] ibus_pc,
  output logic        ibus_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [1:0]  DEPTH      = 2'(BUF_DEPTH);
  localparam logic [63:0] RESET_WORD = {RESET_PC[63:2], 2'b00};

  state_e      state_q;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_addr_q;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic [63:0] buf_pc_q   [2];
  logic [31:0] buf_data_q [2];
  logic [31:0] ibus_q;
  logic [63:0] ibus_pc_q;
  logic        ibus_valid_q;

  logic        issue, push, pop;
  logic [63:0] target_pc;
  logic        unused_target_lsbs;

  assign target_pc          = {redirect_pc[63:2], 2'b00};
  assign unused_target_lsbs = ^redirect_pc[1:0];

  // Redirect suppresses every normal event; the strobes below already fold it in.
  always_comb begin
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    fetch_pc_d = fetch_pc_q;
    if (!redirect) begin
      issue = (state_q == IDLE) && (count_q < DEPTH);
      push  = (state_q == WAIT) && imem_ack;
      pop   = !stall && (count_q != 2'd0);
    end
    if (push) fetch_pc_d = fetch_pc_q + 64'd4;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  assign imem_req  = reset_n && ((state_q != IDLE) || issue);
  assign imem_addr = (state_q == IDLE) ? fetch_pc_q : req_addr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_WORD;
      req_addr_q   <= RESET_WORD;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      ibus_q       <= 32'h0;
      ibus_pc_q    <= 64'h0;
      ibus_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (issue) begin
          state_q    <= WAIT;
          req_addr_q <= fetch_pc_q;
        end
        WAIT: begin
          if (imem_ack)      state_q <= IDLE;
          else if (redirect) state_q <= DROP;
        end
        DROP: if (imem_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (redirect) begin
        fetch_pc_q   <= target_pc;
        count_q      <= 2'd0;
        rd_ptr_q     <= 1'b0;
        wr_ptr_q     <= 1'b0;
        ibus_q       <= 32'h0;
        ibus_pc_q    <= 64'h0;
        ibus_valid_q <= 1'b0;
      end else begin
        fetch_pc_q <= fetch_pc_d;
        count_q    <= count_d;
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop) begin
          rd_ptr_q     <= ~rd_ptr_q;
          ibus_q       <= buf_data_q[rd_ptr_q];
          ibus_pc_q    <= buf_pc_q[rd_ptr_q];
          ibus_valid_q <= 1'b1;
        end else if (!stall) begin
          ibus_q       <= 32'h0;
          ibus_pc_q    <= 64'h0;
          ibus_valid_q <= 1'b0;
        end
      end
    end
  end

  // NOTE: buffer storage has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_data_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign ibus       = ibus_q;
  assign ibus_pc    = ibus_pc_q;
  assign ibus_valid = ibus_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based transaction model predicts
// memory requests and the instruction stream cycle by cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] ibus;
  logic [63:0] ibus_pc;
  logic        ibus_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ibus       (ibus),
    .ibus_pc    (ibus_pc),
    .ibus_valid (ibus_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } entry_t;

  // Model: an in-flight request (possibly doomed), a word queue, and the output word.
  entry_t      fifo[$];
  bit          m_busy;
  bit          m_doomed;
  logic [63:0] m_pc;
  logic [63:0] m_req_addr;
  logic [31:0] e_ibus;
  logic [63:0] e_ibus_pc;
  logic        e_valid;

  task automatic model_reset();
    fifo.delete();
    m_busy     = 0;
    m_doomed   = 0;
    m_pc       = 64'h0;
    m_req_addr = 64'h0;
    e_ibus     = 32'h0;
    e_ibus_pc  = 64'h0;
    e_valid    = 1'b0;
  endtask

  task automatic model_step();
    entry_t e;
    bit     will_issue;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (redirect) begin
      if (m_busy) begin
        if (imem_ack) begin
          m_busy   = 0;
          m_doomed = 0;
        end else begin
          m_doomed = 1;
        end
      end
      m_pc = {redirect_pc[63:2], 2'b00};
      fifo.delete();
      e_ibus    = 32'h0;
      e_ibus_pc = 64'h0;
      e_valid   = 1'b0;
      return;
    end
    will_issue = !m_busy && (fifo.size() < 2);
    if (!stall) begin
      if (fifo.size() > 0) begin
        e         = fifo.pop_front();
        e_ibus    = e.data;
        e_ibus_pc = e.pc;
        e_valid   = 1'b1;
      end else begin
        e_ibus    = 32'h0;
        e_ibus_pc = 64'h0;
        e_valid   = 1'b0;
      end
    end
    if (m_busy && imem_ack) begin
      if (!m_doomed) begin
        e.pc   = m_pc;
        e.data = imem_rdata;
        fifo.push_back(e);
        m_pc = m_pc + 64'd4;
      end
      m_busy   = 0;
      m_doomed = 0;
    end else if (will_issue) begin
      m_busy     = 1;
      m_req_addr = m_pc;
    end
  endtask

  function automatic logic [63:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 64'h1003;
      1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic        exp_req;
    logic [63:0] exp_addr;
    int          stall_run;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    stall_run   = 0;
    @(posedge clk);
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      reset_n     = !(cyc < 2 || $urandom_range(0, 299) == 0);
      imem_rdata  = $urandom();
      redirect_pc = pick_target();
      if (cyc < 40) begin
        // Clean stream from reset, then a fixed 6-cycle stall window.
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = m_busy;
      end else if (cyc < 46) begin
        stall    = 1'b1;
        redirect = 1'b0;
        imem_ack = m_busy;
      end else begin
        if (stall_run == 0) begin
          stall     = ($urandom_range(0, 2) == 0);
          stall_run = $urandom_range(1, 8);
        end
        stall_run--;
        redirect = ($urandom_range(0, 11) == 0);
        imem_ack = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      end
      #1;
      exp_req  = reset_n && (m_busy || (fifo.size() < 2 && !redirect));
      exp_addr = m_busy ? m_req_addr : m_pc;
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, exp_addr);
      check("ibus_valid", ibus_valid, e_valid);
      check("ibus_pc", ibus_pc, e_ibus_pc);
      check("ibus", ibus, e_ibus);
      @(posedge clk);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
